// File: rtl/fetch_redirect_unit_pkg.sv
// Shared types and constants for the IF-stage PC sequencer.
// Fetch states, default reset PC / NOP encoding and the buffered fetch entry layout.
package fetch_redirect_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        DROP  = 2'd2
    } fru_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_redirect_unit_if_id_reg.sv
// IF/ID pipeline register: stall holds, flush inserts a NOP, load captures a
// delivered instruction, otherwise a bubble is marked invalid.
module if_id_reg
    import fetch_redirect_unit_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc4,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
);

    logic [31:0] instr_reg;
    logic [31:0] pc4_reg;
    logic        valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_reg <= NOP_WORD;
            pc4_reg   <= 32'd0;
            valid_reg <= 1'b0;
        end else if (stall) begin
            instr_reg <= instr_reg;
            pc4_reg   <= pc4_reg;
            valid_reg <= valid_reg;
        end else if (flush) begin
            instr_reg <= NOP_WORD;
            valid_reg <= 1'b0;
        end else if (load) begin
            instr_reg <= load_instr;
            pc4_reg   <= load_pc4;
            valid_reg <= 1'b1;
        end else begin
            // Bubble: contents are don't-care once valid drops.
            valid_reg <= 1'b0;
        end
    end

    assign ifid_instr = instr_reg;
    assign ifid_pc4   = pc4_reg;
    assign ifid_valid = valid_reg;

endmodule

// File: rtl/fetch_redirect_unit.sv
// IF-stage PC sequencer: drives the instruction-memory req/ack handshake, redirects
// on ID-stage branch/jump resolution, squashes wrong-path fetches and buffers one stalled fetch.
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        if_flush,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
);

    fru_state_e   state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  drop_addr_reg, drop_addr_next;
    fetch_entry_t fetch_buf_reg, fetch_buf_next;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic         deliver;
    fetch_entry_t deliver_entry;

    // Flush is only honoured once ID has valid branch operands, i.e. not while stalled.
    assign redirect = if_flush & ~stall;
    assign target   = branch_taken ? branch_target : jump_target;
    assign pc_plus4 = pc_reg + PC_INC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= FETCH;
            pc_reg        <= RESET_PC;
            drop_addr_reg <= RESET_PC;
            fetch_buf_reg <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            drop_addr_reg <= drop_addr_next;
            fetch_buf_reg <= fetch_buf_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        drop_addr_next = drop_addr_reg;
        fetch_buf_next = fetch_buf_reg;
        imem_req       = 1'b0;
        imem_addr      = pc_reg;
        deliver        = 1'b0;
        deliver_entry  = fetch_buf_reg;

        case (state_reg)
            FETCH: begin
                imem_req = ~rst;
                if (imem_ack) begin
                    if (redirect) begin
                        pc_next = target;
                    end else if (!stall) begin
                        deliver       = 1'b1;
                        deliver_entry = '{instr: imem_rdata, pc4: pc_plus4};
                        pc_next       = pc_plus4;
                    end else begin
                        fetch_buf_next = '{instr: imem_rdata, pc4: pc_plus4};
                        pc_next        = pc_plus4;
                        state_next     = FULL;
                    end
                end else if (redirect) begin
                    drop_addr_next = pc_reg;
                    pc_next        = target;
                    state_next     = DROP;
                end
            end
            FULL: begin
                if (redirect) begin
                    fetch_buf_next = '0;
                    pc_next        = target;
                    state_next     = FETCH;
                end else if (!stall) begin
                    deliver    = 1'b1;
                    state_next = FETCH;
                end
            end
            DROP: begin
                // An outstanding request cannot be abandoned; keep presenting the old address.
                imem_req  = ~rst;
                imem_addr = drop_addr_reg;
                if (redirect) begin
                    pc_next = target;
                end
                if (imem_ack) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (redirect),
        .load       (deliver),
        .load_instr (deliver_entry.instr),
        .load_pc4   (deliver_entry.pc4),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid)
    );

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- IF-stage PC sequencer and IF/ID pipeline register.
- Consumes the ID-stage branch resolution outputs (branch-taken and IF-flush) together with branch/jump targets, and redirects the PC.
- Squashes the wrong-path fetch.
- Talks to instruction memory over a req/ack handshake, and absorbs hazard-unit stalls with a one-entry buffer.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_WORD, 32'h00000000, instruction word placed in IF/ID on flush or reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- branch_taken  in  1  ID-stage beq resolved taken.
- if_flush  in  1  ID-stage redirect (taken branch or jump).
- branch_target  in  32  target used when if_flush & branch_taken.
- jump_target  in  32  target used when if_flush & !branch_taken.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and no ack.
- imem_ack  in  1  one-cycle response strobe; may arrive in the same cycle as req.
- imem_rdata  in  32  instruction, valid only with imem_ack.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc4  out  32  IF/ID PC+4 of that instruction.
- ifid_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async): pc=RESET_PC, state=FETCH, buf empty, ifid_instr=NOP_WORD, ifid_pc4=0, ifid_valid=0, imem_req=0.
  - imem_req rises in the first cycle after rst deasserts.
- redirect = if_flush & !stall.
  - if_flush is ignored while stall=1 (branch operands in ID are not yet valid).
  - target = branch_taken ? branch_target : jump_target.
- PC arithmetic is 32-bit modulo: 32'hFFFFFFFC + 4 = 0.
- IF/ID update each edge:
  - If stall: hold all three fields.
  - Else if redirect: load NOP_WORD, ifid_valid=0.
  - Else if an instruction is delivered: load {instr, pc+4}, ifid_valid=1.
  - Else: ifid_valid=0 (bubble).
- State FETCH: imem_req=1, imem_addr=pc.
  - ack & redirect: discard rdata; pc<=target; stay FETCH.
  - ack & !stall: deliver rdata to IF/ID; pc<=pc+4; stay FETCH (back-to-back fetch, one instruction per cycle with zero-wait memory).
  - ack & stall: capture {rdata, pc+4} into buf; pc<=pc+4; go FULL.
  - no ack & redirect: latch old pc as drop_addr; pc<=target; go DROP.
  - no ack otherwise: stay FETCH, request held.
- State FULL: imem_req=0.
  - redirect: clear buf; go FETCH (pc<=target).
  - !stall: deliver buf to IF/ID; go FETCH.
  - stall: hold.
- State DROP: imem_req=1, imem_addr=drop_addr (the protocol forbids abandoning a request).
  - ack: discard rdata, go FETCH.
  - Further redirect in DROP: pc<=new target (latest wins), stay DROP.
  - Redirect and ack in the same cycle: pc<=new target and go FETCH.
- Latency: fetch to IF/ID is 1 edge after ack when not stalled. Redirect to first target fetch request is the next cycle (FETCH/FULL) or the cycle after the dropped ack (DROP).
- The stall input never blocks imem_req in FETCH or DROP. Only FULL deasserts req.

Decomposition:
- Shared package holds:
  - State enum {FETCH, FULL, DROP}.
  - NOP_WORD and RESET_PC defaults.
  - PC_INC=32'd4.
- One natural sub-module: if_id_reg (flush/stall/load priority register for instr, pc4, valid). The FSM, PC, buf and drop_addr stay in the top.

Test Plan:
- Zero-wait ack every cycle, no stall/flush, RESET_PC=0 -> imem_addr 0,4,8,C on consecutive cycles; ifid_pc4 4,8,C one cycle later; ifid_valid=1 from the 2nd cycle after reset.
- Branch: at fetch of 0x10, if_flush=1, branch_taken=1, branch_target=0x100 -> next IF/ID = NOP_WORD with valid=0; next imem_addr=0x100; 0x10's instruction is never delivered.
- Jump: if_flush=1, branch_taken=0, jump_target=0x40, branch_target=0x100 -> next imem_addr=0x40.
- Stall with ack: stall=1 for 3 cycles while ack returns for 0x8 -> FULL, imem_req=0, IF/ID held; when stall drops, IF/ID gets 0x8's word with pc4=0xC the next edge; then fetch resumes at 0xC.
- Redirect during a 3-cycle-latency fetch of 0x20, target 0x80 -> imem_addr stays 0x20 until ack; that rdata is discarded; next request is 0x80. A second redirect to 0x90 mid-DROP yields request 0x90.
- if_flush=1 together with stall=1 -> no redirect and IF/ID held. Separately, assert rst mid-DROP -> outputs return to their reset values immediately; after release, the first request is to RESET_PC.
